// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit 7-segment scan driver.
package display_pkg;

  typedef enum logic [1:0] {
    S_LEFT,
    S_BLANK_LR,
    S_RIGHT,
    S_BLANK_RL
  } scan_state_t;

  localparam logic [1:0] AN_LEFT   = 2'b10;
  localparam logic [1:0] AN_RIGHT  = 2'b01;
  localparam logic [1:0] AN_OFF    = 2'b00;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high anode pattern for a scan state; guard states keep both digits dark.
  function automatic logic [1:0] state_anode(input scan_state_t s);
    logic [1:0] a;
    a = AN_OFF;
    unique case (s)
      S_LEFT:  a = AN_LEFT;
      S_RIGHT: a = AN_RIGHT;
      default: a = AN_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/module_tick_gen.sv
// Generic free-running divider: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous restart forces the count back to 0 and suppresses that cycle's tick.
module module_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned    CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Divider counter: wraps straight to 0 after the last count, no overflow cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_LAST) && !restart;

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed driver for two 7-segment digits: left shows the corrected word,
// right shows the error code. Blanking guards separate the digits to avoid ghosting,
// and the right digit blinks while a double error is flagged.
module module_display_scan
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 27_000_000,
  parameter int unsigned REFRESH_HZ    = 1000,
  parameter int unsigned BLANK_CYCLES  = 270,
  parameter int unsigned BLINK_HZ      = 2,
  parameter bit          AN_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_word,
  input  logic [6:0] seg_error,
  input  logic       error_doble,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int unsigned SLOT        = CLK_HZ / (2 * REFRESH_HZ);
  localparam int unsigned BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SLOT_ACTIVE = SLOT - BLANK_CYCLES;
  localparam int unsigned CNT_MAX     = (SLOT_ACTIVE > BLANK_CYCLES) ?
                                        SLOT_ACTIVE - 1 : BLANK_CYCLES - 1;
  localparam int unsigned CNT_W       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(SLOT_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       AN_MASK     = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

  if (BLANK_CYCLES == 0 || BLANK_CYCLES >= SLOT) begin : g_bad_cfg
    $error("module_display_scan: BLANK_CYCLES must be in 1..SLOT-1");
  end

  // ---------------------------------------------------------------------------
  // Blink phase for the right digit
  // ---------------------------------------------------------------------------
  logic dbl_prev_q;
  logic blink_on_q;
  logic blink_wrap;
  logic dbl_rise;

  assign dbl_rise = error_doble && !dbl_prev_q;

  module_tick_gen #(
    .DIV(BLINK_HALF)
  ) u_blink_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(dbl_rise),
    .tick   (blink_wrap)
  );

  // Blink phase: a fresh double error always starts with the digit visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbl_prev_q <= 1'b0;
      blink_on_q <= 1'b1;
    end else begin
      dbl_prev_q <= error_doble;
      if (dbl_rise) begin
        blink_on_q <= 1'b1;
      end else if (blink_wrap) begin
        blink_on_q <= !blink_on_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  scan_state_t      state_q;
  scan_state_t      state_next;
  logic [CNT_W-1:0] slot_cnt_q;
  logic [CNT_W-1:0] slot_last;
  logic [6:0]       word_q;
  logic [6:0]       err_q;
  logic             dbl_q;

  // Successor state and dwell length of the current state.
  always_comb begin
    state_next = state_q;
    slot_last  = BLANK_LAST;
    unique case (state_q)
      S_LEFT: begin
        state_next = S_BLANK_LR;
        slot_last  = ACTIVE_LAST;
      end
      S_BLANK_LR: begin
        state_next = S_RIGHT;
        slot_last  = BLANK_LAST;
      end
      S_RIGHT: begin
        state_next = S_BLANK_RL;
        slot_last  = ACTIVE_LAST;
      end
      S_BLANK_RL: begin
        state_next = S_LEFT;
        slot_last  = BLANK_LAST;
      end
      default: begin
        state_next = S_BLANK_RL;
        slot_last  = BLANK_LAST;
      end
    endcase
  end

  // State, input capture and registered outputs. Outputs are derived from the
  // current state register, so anode and segments change together one cycle
  // after each state change and an can never show both digits at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BLANK_RL;
      slot_cnt_q <= '0;
      word_q     <= SEG_BLANK;
      err_q      <= SEG_BLANK;
      dbl_q      <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= AN_OFF ^ AN_MASK;
      frame_tick <= 1'b0;
    end else begin
      an         <= state_anode(state_q) ^ AN_MASK;
      frame_tick <= 1'b0;
      unique case (state_q)
        S_LEFT: begin
          seg        <= word_q;
          frame_tick <= (slot_cnt_q == '0);
        end
        S_RIGHT: begin
          seg <= (blink_on_q || !dbl_q) ? err_q : SEG_BLANK;
        end
        default: begin
          seg <= SEG_BLANK;
        end
      endcase

      if (slot_cnt_q == slot_last) begin
        slot_cnt_q <= '0;
        state_q    <= state_next;
        // Inputs are latched only on slot entry so a digit never changes mid-slot.
        if (state_next == S_LEFT) begin
          word_q <= seg_word;
        end
        if (state_next == S_RIGHT) begin
          err_q <= seg_error;
          dbl_q <= error_doble;
        end
      end else begin
        slot_cnt_q <= slot_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Directed bench for module_display_scan with SLOT=10, BLANK_CYCLES=2, BLINK_HALF=100.
// A second instance with inverted anodes runs in lock-step on the same stimulus.
module tb_module_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_word;
  logic [6:0] seg_error;
  logic       error_doble;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
  logic [6:0] seg_low;
  logic [1:0] an_low;
  logic       frame_tick_low;

  int checks   = 0;
  int failures = 0;
  logic [3:0] seen_an_low = 4'b0000;

  always #5 clk = ~clk;

  module_display_scan #(
    .CLK_HZ(1000), .REFRESH_HZ(50), .BLANK_CYCLES(2), .BLINK_HZ(5), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_word   (seg_word),
    .seg_error  (seg_error),
    .error_doble(error_doble),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  module_display_scan #(
    .CLK_HZ(1000), .REFRESH_HZ(50), .BLANK_CYCLES(2), .BLINK_HZ(5), .AN_ACTIVE_LOW(1'b1)
  ) dut_low (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_word   (seg_word),
    .seg_error  (seg_error),
    .error_doble(error_doble),
    .seg        (seg_low),
    .an         (an_low),
    .frame_tick (frame_tick_low)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all outputs at frame position pos (0 = first cycle the left digit is lit).
  task automatic check_pos(input int pos, input logic [6:0] w, input logic [6:0] e);
    logic [1:0] ea;
    logic [6:0] es;
    if (pos < 8) begin
      ea = 2'b10; es = w;
    end else if (pos < 10) begin
      ea = 2'b00; es = 7'h00;
    end else if (pos < 18) begin
      ea = 2'b01; es = e;
    end else begin
      ea = 2'b00; es = 7'h00;
    end
    chk($sformatf("an@%0d", pos), {6'b0, an}, {6'b0, ea});
    chk($sformatf("seg@%0d", pos), {1'b0, seg}, {1'b0, es});
    chk($sformatf("frame_tick@%0d", pos), {7'b0, frame_tick}, {7'b0, pos == 0});
    chk($sformatf("an_low@%0d", pos), {6'b0, an_low}, {6'b0, ~ea});
    chk($sformatf("seg_low@%0d", pos), {1'b0, seg_low}, {1'b0, es});
    seen_an_low[an_low] = 1'b1;
  endtask

  // One full 20-cycle frame; optionally change seg_word after position chg_idx.
  task automatic check_frame(input logic [6:0] w, input logic [6:0] e,
                             input int chg_idx, input logic [6:0] new_w);
    for (int i = 0; i < 20; i++) begin
      check_pos(i, w, e);
      if (i == chg_idx) seg_word = new_w;
      @(negedge clk);
    end
  endtask

  // After reset release: two dark cycles, then the frame starts.
  task automatic check_release(input string tag);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("%s_an_dark%0d", tag, i), {6'b0, an}, 8'h00);
      chk($sformatf("%s_ft_dark%0d", tag, i), {7'b0, frame_tick}, 8'h00);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    seg_word    = 7'h3F;
    seg_error   = 7'h06;
    error_doble = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_an", {6'b0, an}, 8'h00);
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_ft", {7'b0, frame_tick}, 8'h00);
    chk("rst_an_low", {6'b0, an_low}, 8'h03);

    // Scan timing and basic digit contents
    check_release("rel1");
    check_frame(7'h3F, 7'h06, -1, 7'h00);
    // Word changes mid-left-slot: current slot keeps 3F, next frame shows 5B
    check_frame(7'h3F, 7'h06, 3, 7'h5B);
    check_frame(7'h5B, 7'h06, -1, 7'h00);

    // Double error: right digit visible 100 cycles, dark 100, visible again
    for (int k = 0; k < 300; k++) begin
      check_pos(k % 20, 7'h5B, ((k < 100) || (k >= 200)) ? 7'h06 : 7'h00);
      if (k == 0) error_doble = 1'b1;
      @(negedge clk);
    end
    error_doble = 1'b0;

    // Reset asserted mid-right-slot blanks outputs asynchronously
    for (int i = 0; i < 12; i++) begin
      check_pos(i, 7'h5B, 7'h06);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_an", {6'b0, an}, 8'h00);
    chk("midrst_seg", {1'b0, seg}, 8'h00);
    chk("midrst_ft", {7'b0, frame_tick}, 8'h00);
    chk("midrst_an_low", {6'b0, an_low}, 8'h03);
    @(negedge clk);
    check_release("rel2");
    check_frame(7'h5B, 7'h06, -1, 7'h00);

    // Long run for the inverted-anode instance
    seg_word  = 7'h4F;
    seg_error = 7'h66;
    check_frame(7'h5B, 7'h66, -1, 7'h00);
    repeat (25) check_frame(7'h4F, 7'h66, -1, 7'h00);
    chk("an_low_seen_set", {4'b0, seen_an_low}, 8'h0E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
